msdap_conv_scheduler: RTL and testbench

MSDAP_CONV_SCHEDULER -- requirements
Module: msdap_conv_scheduler

---
 rtl/msdap_pkg.sv | 22 ++
 rtl/msdap_group_counter.sv | 45 ++++
 rtl/msdap_conv_scheduler.sv | 137 +++++++++++++
 tb/tb_msdap_conv_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/msdap_pkg.sv
// Shared definitions for the MSDAP convolution scheduler: memory sizes,
// ALU op encoding and scheduler state encoding.
package msdap_pkg;

    localparam int ORDER     = 256;
    localparam int NUM_RJ    = 16;
    localparam int NUM_COEFF = 512;

    // ALU op bits: bit0 selects subtract, bit1 requests a right shift after the add.
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_LATCH,
        S_DONE
    } state_t;

endpackage

// File: rtl/msdap_group_counter.sv
// Walks the RJ groups of one channel: tracks the group index and the position
// inside the group, and flags the shift op and the final group.
module msdap_group_counter #(
    parameter int NUM_RJ = msdap_pkg::NUM_RJ,
    parameter int CNT_W  = 8
) (
    input  logic                      sclk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      step,
    input  logic [CNT_W-1:0]          rj_data,
    output logic [$clog2(NUM_RJ)-1:0] rj_idx,
    output logic                      zero_group,
    output logic                      shift,
    output logic                      last_group
);

    localparam int RW = $clog2(NUM_RJ);

    logic [CNT_W-1:0] cnt;

    // An empty group still costs one op, and that op is its shift.
    assign zero_group = (rj_data == '0);
    assign shift      = zero_group || (cnt == rj_data - CNT_W'(1));
    assign last_group = (rj_idx == RW'(NUM_RJ - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            rj_idx <= '0;
            cnt    <= '0;
        end else if (clr) begin
            rj_idx <= '0;
            cnt    <= '0;
        end else if (step) begin
            if (shift) begin
                rj_idx <= rj_idx + RW'(1);
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/msdap_conv_scheduler.sv
// Sequences the shared ALU through the sign/delay coefficient schedule for the
// left then right channel each time a new sample frame arrives.
module msdap_conv_scheduler #(
    parameter int ORDER     = msdap_pkg::ORDER,
    parameter int NUM_RJ    = msdap_pkg::NUM_RJ,
    parameter int NUM_COEFF = msdap_pkg::NUM_COEFF
) (
    input  logic                         sclk,
    input  logic                         reset,
    input  logic                         start_frame,
    input  logic [$clog2(ORDER)-1:0]     n_ptr,
    output logic [$clog2(NUM_RJ)-1:0]    rj_addr,
    input  logic [7:0]                   rj_data,
    output logic [$clog2(NUM_COEFF)-1:0] coeff_addr,
    input  logic [$clog2(ORDER):0]       coeff_data,
    output logic [$clog2(ORDER)-1:0]     data_addr,
    output logic                         chan,
    output logic                         alu_valid,
    output logic [1:0]                   alu_op,
    output logic                         alu_zero,
    output logic                         alu_clr,
    output logic                         result_latch,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);

    import msdap_pkg::*;

    localparam int DW = $clog2(ORDER);
    localparam int CW = $clog2(NUM_COEFF);

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] n_reg;
    logic [CW-1:0] coeff_idx;
    logic          grp_clr;
    logic          grp_zero;
    logic          grp_shift;
    logic          grp_last;

    msdap_group_counter #(
        .NUM_RJ (NUM_RJ),
        .CNT_W  (8)
    ) u_group_counter (
        .sclk       (sclk),
        .reset      (reset),
        .clr        (grp_clr),
        .step       (alu_valid),
        .rj_data    (rj_data),
        .rj_idx     (rj_addr),
        .zero_group (grp_zero),
        .shift      (grp_shift),
        .last_group (grp_last)
    );

    assign coeff_addr = coeff_idx;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            chan      <= 1'b0;
            n_reg     <= '0;
            coeff_idx <= '0;
            overrun   <= 1'b0;
        end else begin
            state   <= state_next;
            // A frame arriving mid-schedule is dropped; only the flag records it.
            overrun <= start_frame && (state != S_IDLE);
            if (state == S_IDLE && start_frame) begin
                chan      <= 1'b0;
                n_reg     <= n_ptr;
                coeff_idx <= '0;
            end
            if (state == S_LATCH && !chan) begin
                chan <= 1'b1;
            end
            // Coefficient index runs on across both channels and wraps naturally.
            if (state == S_RUN && !grp_zero) begin
                coeff_idx <= coeff_idx + CW'(1);
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        state_next   = state;
        grp_clr      = 1'b0;
        alu_valid    = 1'b0;
        alu_op       = OP_ADD;
        alu_zero     = 1'b0;
        alu_clr      = 1'b0;
        result_latch = 1'b0;
        done         = 1'b0;
        data_addr    = '0;

        case (state)
            S_IDLE: begin
                if (start_frame) begin
                    state_next = S_CLR;
                end
            end
            S_CLR: begin
                alu_clr    = 1'b1;
                grp_clr    = 1'b1;
                state_next = S_RUN;
            end
            S_RUN: begin
                alu_valid = 1'b1;
                data_addr = n_reg - coeff_data[DW-1:0];
                if (grp_zero) begin
                    alu_zero = 1'b1;
                    alu_op   = OP_SHIFT;
                end else begin
                    alu_op = (coeff_data[DW] ? OP_SUB : OP_ADD) |
                             (grp_shift ? OP_SHIFT : OP_ADD);
                end
                if (grp_shift && grp_last) begin
                    state_next = S_LATCH;
                end
            end
            S_LATCH: begin
                result_latch = 1'b1;
                state_next   = chan ? S_DONE : S_CLR;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_msdap_conv_scheduler.sv
// Directed bench for msdap_conv_scheduler: a frame model queues the expected op
// stream, and each issued ALU op is popped and compared as it appears.
module tb_msdap_conv_scheduler;

    typedef struct packed {
        logic       chan;
        logic       zero;
        logic [1:0] op;
        logic [8:0] caddr;
        logic [3:0] raddr;
        logic [7:0] daddr;
    } op_t;

    logic       sclk;
    logic       reset;
    logic       start_frame;
    logic [7:0] n_ptr;
    logic [3:0] rj_addr;
    logic [7:0] rj_data;
    logic [8:0] coeff_addr;
    logic [8:0] coeff_data;
    logic [7:0] data_addr;
    logic       chan;
    logic       alu_valid;
    logic [1:0] alu_op;
    logic       alu_zero;
    logic       alu_clr;
    logic       result_latch;
    logic       busy;
    logic       done;
    logic       overrun;

    logic [7:0] rj_mem    [16];
    logic [8:0] coeff_mem [512];

    op_t exp_q [$];
    int  n_cmp;
    int  n_bad;
    int  op_cnt;
    int  done_cnt;
    int  latch_cnt;
    int  clr_cnt;
    int  ovr_cnt;
    int  zero_cnt;
    int  first_t;

    assign rj_data    = rj_mem[rj_addr];
    assign coeff_data = coeff_mem[coeff_addr];

    msdap_conv_scheduler dut (
        .sclk         (sclk),
        .reset        (reset),
        .start_frame  (start_frame),
        .n_ptr        (n_ptr),
        .rj_addr      (rj_addr),
        .rj_data      (rj_data),
        .coeff_addr   (coeff_addr),
        .coeff_data   (coeff_data),
        .data_addr    (data_addr),
        .chan         (chan),
        .alu_valid    (alu_valid),
        .alu_op       (alu_op),
        .alu_zero     (alu_zero),
        .alu_clr      (alu_clr),
        .result_latch (result_latch),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected op stream for one frame: L then R, coefficient index shared.
    task automatic push_frame(input logic [7:0] n, output int ops);
        op_t        e;
        logic [8:0] cidx;
        ops  = 0;
        cidx = '0;
        for (int ch = 0; ch < 2; ch++) begin
            for (int g = 0; g < 16; g++) begin
                if (rj_mem[g] == 8'd0) begin
                    e.chan  = ch[0];
                    e.zero  = 1'b1;
                    e.op    = 2'b10;
                    e.caddr = cidx;
                    e.raddr = g[3:0];
                    e.daddr = 8'd0;
                    exp_q.push_back(e);
                    ops++;
                end else begin
                    for (int k = 0; k < int'(rj_mem[g]); k++) begin
                        e.chan  = ch[0];
                        e.zero  = 1'b0;
                        e.op    = {(k == int'(rj_mem[g]) - 1), coeff_mem[cidx][8]};
                        e.caddr = cidx;
                        e.raddr = g[3:0];
                        e.daddr = n - coeff_mem[cidx][7:0];
                        exp_q.push_back(e);
                        ops++;
                        cidx = cidx + 9'd1;
                    end
                end
            end
        end
    endtask

    // One cycle: observe outputs on the falling edge and score any issued op.
    task automatic sample();
        op_t obs;
        op_t e;
        @(negedge sclk);
        if (alu_valid) begin
            op_cnt++;
            obs.chan  = chan;
            obs.zero  = alu_zero;
            obs.op    = alu_op;
            obs.caddr = coeff_addr;
            obs.raddr = rj_addr;
            obs.daddr = alu_zero ? 8'd0 : data_addr;
            if (alu_zero) zero_cnt++;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL extra_op: observed op %0h expected none", obs);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("op%0d", op_cnt), 64'(obs), 64'(e));
            end
        end else begin
            check("idle_alu", 64'({alu_op, alu_zero}), 64'(0));
        end
        if (done)         done_cnt++;
        if (result_latch) latch_cnt++;
        if (alu_clr)      clr_cnt++;
        if (overrun)      ovr_cnt++;
    endtask

    task automatic clear_counts();
        op_cnt    = 0;
        done_cnt  = 0;
        latch_cnt = 0;
        clr_cnt   = 0;
        ovr_cnt   = 0;
        zero_cnt  = 0;
        first_t   = 0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] n, input int second_at,
                             input bit start_in_done, input int exp_zero);
        int ops;
        int t;
        push_frame(n, ops);
        clear_counts();
        n_ptr       = n;
        start_frame = 1'b1;
        t           = 0;
        do begin
            sample();
            t++;
            if (t == 1) check({tag, "_clr"}, 64'({busy, alu_clr, chan}), 64'(3'b110));
            if (alu_valid && first_t == 0) first_t = t;
            start_frame = (t == second_at);
            if (t == second_at) n_ptr = ~n;
        end while (!done && t < 4000);
        check({tag, "_done_at"}, 64'(t), 64'(ops + 5));
        check({tag, "_first_op"}, 64'(first_t), 64'(2));
        check({tag, "_latches"}, 64'(latch_cnt), 64'(2));
        check({tag, "_clears"}, 64'(clr_cnt), 64'(2));
        check({tag, "_zero_ops"}, 64'(zero_cnt), 64'(exp_zero));
        check({tag, "_ops_left"}, 64'(exp_q.size()), 64'(0));
        start_frame = start_in_done;
        n_ptr       = ~n;
        sample();
        start_frame = 1'b0;
        check({tag, "_after_done"}, 64'({busy, done, result_latch, alu_clr}), 64'(0));
        check({tag, "_overruns"}, 64'(ovr_cnt), 64'((second_at > 0 ? 1 : 0) + (start_in_done ? 1 : 0)));
        sample();
        check({tag, "_frame_dropped"}, 64'({busy, alu_clr}), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        int ops;
        int t;
        n_cmp       = 0;
        n_bad       = 0;
        reset       = 1'b1;
        start_frame = 1'b0;
        n_ptr       = 8'd0;
        clear_counts();
        for (int g = 0; g < 16; g++) rj_mem[g] = 8'd1;
        for (int i = 0; i < 512; i++) coeff_mem[i] = 9'(i);

        repeat (3) sample();
        check("reset_outputs",
              64'({busy, done, overrun, alu_valid, alu_op, alu_zero, alu_clr, result_latch,
                   chan, rj_addr, coeff_addr, data_addr}), 64'(0));
        reset = 1'b0;
        sample();
        check("idle_after_release", 64'({busy, done, overrun}), 64'(0));

        // Unit groups, coefficient i holds delay i: every op shifts.
        run_frame("unit_groups", 8'd10, 0, 1'b0, 0);

        // Full 512-coefficient schedule, all subtracts, index wraps into R.
        for (int g = 0; g < 16; g++) rj_mem[g] = 8'd32;
        for (int i = 0; i < 512; i++) coeff_mem[i] = {1'b1, 8'($urandom_range(0, 255))};
        run_frame("wide_groups", 8'd200, 0, 1'b0, 0);

        // One empty group in the middle of each channel.
        for (int g = 0; g < 16; g++) rj_mem[g] = 8'd2;
        rj_mem[3] = 8'd0;
        for (int i = 0; i < 512; i++) coeff_mem[i] = 9'($urandom_range(0, 511));
        run_frame("empty_group", 8'd77, 0, 1'b0, 2);

        // Frames arriving mid-schedule and in the DONE cycle are dropped.
        for (int g = 0; g < 16; g++) rj_mem[g] = 8'd1;
        for (int i = 0; i < 512; i++) coeff_mem[i] = 9'(i);
        run_frame("overrun", 8'd10, 5, 1'b1, 0);

        // Reset while the right channel is running aborts the frame.
        for (int g = 0; g < 16; g++) rj_mem[g] = 8'd2;
        rj_mem[3] = 8'd0;
        push_frame(8'd20, ops);
        clear_counts();
        n_ptr       = 8'd20;
        start_frame = 1'b1;
        t           = 0;
        do begin
            sample();
            t++;
            start_frame = 1'b0;
        end while (t < ops / 2 + 8 && !done);
        check("abort_in_r_run", 64'({alu_valid, chan}), 64'(2'b11));
        reset = 1'b1;
        #1;
        check("abort_outputs",
              64'({busy, done, overrun, alu_valid, alu_op, alu_zero, alu_clr, result_latch,
                   chan, rj_addr, coeff_addr, data_addr}), 64'(0));
        exp_q.delete();
        repeat (3) sample();
        check("abort_no_done", 64'({done_cnt, latch_cnt}), 64'({32'd0, 32'd1}));
        reset = 1'b0;
        run_frame("post_reset", 8'd20, 0, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
